// File: rtl/barret_1973_pkg.sv
// Shared constants for GF(1973) arithmetic blocks.
// Holds the modulus, datapath widths and the Barrett constant used by
// barret_for_1973 and any other block working in the prime field GF(1973).
package barret_1973_pkg;

  localparam int unsigned MODULUS = 1973;
  localparam int unsigned DIN_W   = 21;
  localparam int unsigned DOUT_W  = 11;
  localparam int unsigned SHIFT_K = 22;
  localparam int unsigned MU      = 2125;
  localparam int unsigned MU_W    = 12;
  localparam int unsigned PROD_W  = 33;
  // Quotient estimate width: floor((2^21-1)*2125 / 2^22) = 1062 fits in 11 bits.
  localparam int unsigned Q_W     = 11;
  // Partial remainder width: t < 3*MODULUS = 5919 fits in 13 bits.
  localparam int unsigned T_W     = 13;

endpackage : barret_1973_pkg

// File: rtl/barret_1973_corr.sv
// Final correction of the Barrett partial remainder.
// Ports:
//   t     - partial remainder, guaranteed < 3*MODULUS
//   rem_c - fully reduced remainder in 0..MODULUS-1 (combinational)
module barret_1973_corr
  import barret_1973_pkg::*;
(
  input  logic [T_W-1:0]    t,
  output logic [DOUT_W-1:0] rem_c
);

  logic ge_two_c;
  logic ge_one_c;

  // Both thresholds are compared in parallel; the larger one wins.
  always_comb begin
    ge_two_c = (t >= T_W'(2 * MODULUS));
    ge_one_c = (t >= T_W'(MODULUS));
    rem_c    = DOUT_W'(t);
    if (ge_two_c) begin
      rem_c = DOUT_W'(t - T_W'(2 * MODULUS));
    end else if (ge_one_c) begin
      rem_c = DOUT_W'(t - T_W'(MODULUS));
    end
  end

endmodule : barret_1973_corr

// File: rtl/barret_for_1973.sv
// Registered Barrett reducer: dout_r = din_a mod 1973, one result per clock.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset, clears all pipeline registers
//   din_a  - 21-bit unsigned value to reduce
//   dout_r - registered remainder in 0..1972
// Optional macro BARRET_1973_PIPE_EN inserts a register stage after the
// multiply (quotient estimate plus delayed input), raising latency to 2.
module barret_for_1973
  import barret_1973_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din_a,
  output logic [DOUT_W-1:0] dout_r
);

  logic [PROD_W-1:0] prod_c;
  logic [Q_W-1:0]    q_c;
  logic [Q_W-1:0]    q_s;
  logic [DIN_W-1:0]  din_s;
  logic [DIN_W-1:0]  qm_c;
  logic [T_W-1:0]    t_c;
  logic [DOUT_W-1:0] rem_c;
  logic [DOUT_W-1:0] dout_d;
  logic [DOUT_W-1:0] dout_q;

  // Quotient estimate q = floor(din_a * MU / 2^SHIFT_K).
  always_comb begin
    prod_c = PROD_W'(din_a) * PROD_W'(MU);
    q_c    = Q_W'(prod_c >> SHIFT_K);
  end

`ifdef BARRET_1973_PIPE_EN
  logic [Q_W-1:0]   q_d;
  logic [Q_W-1:0]   q_q;
  logic [DIN_W-1:0] din_d;
  logic [DIN_W-1:0] din_q;

  always_comb begin
    q_d   = q_c;
    din_d = din_a;
  end

  // Timing-closure stage between the multiply and the subtract.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      din_q <= '0;
    end else begin
      q_q   <= q_d;
      din_q <= din_d;
    end
  end

  always_comb begin
    q_s   = q_q;
    din_s = din_q;
  end
`else
  always_comb begin
    q_s   = q_c;
    din_s = din_a;
  end
`endif

  // q*MODULUS never exceeds din, so the 21-bit difference is exact and
  // its low 13 bits hold the whole partial remainder.
  always_comb begin
    qm_c = DIN_W'(q_s) * DIN_W'(MODULUS);
    t_c  = T_W'(din_s - qm_c);
  end

  barret_1973_corr u_corr (
    .t     (t_c),
    .rem_c (rem_c)
  );

  always_comb begin
    dout_d = rem_c;
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_r = dout_q;

endmodule : barret_for_1973

// File: tb/tb_barret_for_1973.sv
// Self-checking bench for barret_for_1973: table vectors, directed reset
// sequences and a random stream compared against x % 1973 delayed by the
// configured latency.
module tb_barret_for_1973;

`ifdef BARRET_1973_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int unsigned P = 1973;

  logic        clk;
  logic        rst;
  logic [20:0] din_a;
  logic [10:0] dout_r;

  int checks;
  int failures;

  // Expected output history: index 0 is what dout_r should show now.
  int unsigned model_q [2];

  typedef struct {
    int unsigned din;
    int unsigned exp;
  } vec_t;

  vec_t tbl [10];

  barret_for_1973 dut (
    .clk    (clk),
    .rst    (rst),
    .din_a  (din_a),
    .dout_r (dout_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one input at the falling edge, advance the model on the rising
  // edge, and compare at the next falling edge.
  task automatic step(input int unsigned d, input logic r, input string name);
    din_a = 21'(d);
    rst   = r;
    @(posedge clk);
    if (r) begin
      model_q[0] = 0;
      model_q[1] = 0;
    end else begin
      for (int i = 0; i < LAT - 1; i++) model_q[i] = model_q[i + 1];
      model_q[LAT - 1] = d % P;
    end
    @(negedge clk);
    chk(name, 32'(dout_r), model_q[0]);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_q[0] = 0;
    model_q[1] = 0;
    rst   = 1'b1;
    din_a = '0;

    tbl[0] = '{1973,    0};
    tbl[1] = '{3945,    1972};
    tbl[2] = '{3946,    0};
    tbl[3] = '{5919,    0};
    tbl[4] = '{2097151, 1825};
    tbl[5] = '{2095326, 0};
    tbl[6] = '{2095325, 1972};
    tbl[7] = '{0,       0};
    tbl[8] = '{1972,    1972};
    tbl[9] = '{1974,    1};

    // Reset held with a live input: output stays zero.
    for (int i = 0; i < 3; i++) begin
      step(1234, 1'b1, "reset_hold");
      chk("reset_zero", 32'(dout_r), 0);
    end
    // Release: the first unreset sample appears after LAT cycles.
    for (int i = 0; i < LAT; i++) step(1234, 1'b0, "reset_release");
    chk("reset_first_value", 32'(dout_r), 1234);

    // Identity sweep below the modulus.
    for (int unsigned v = 0; v < P; v++) step(v, 1'b0, "identity");
    for (int i = 0; i < LAT - 1; i++) step(0, 1'b0, "identity_flush");

    // Table vectors: hold each value for LAT cycles, then compare to the table.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < LAT; i++) step(tbl[k].din, 1'b0, "table_model");
      chk("table_vec", 32'(dout_r), tbl[k].exp);
    end

    // Mid-stream reset discards the in-flight value.
    step(100, 1'b0, "midrst_100");
    step(200, 1'b1, "midrst_200");
    chk("midrst_zero", 32'(dout_r), 0);
    step(300, 1'b0, "midrst_300");
    for (int i = 0; i < LAT; i++) step(400, 1'b0, "midrst_400");
    chk("midrst_after", 32'(dout_r), 400);

    // Back-to-back random stream.
    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(2097151, 0), 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_barret_for_1973
